rf_write_arbiter: RTL and testbench

//  Owns the single write port of the 8x8 register file.

---
 rtl/rf_write_arbiter_if.sv | 36 +++
 rtl/rf_write_arbiter.sv | 85 ++++++++
 tb/tb_rf_write_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle of the register-file arbiter: two writeback requesters,
// the clear-sequence control and the registered write port into the file.
interface rf_write_arbiter_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start,
    input  req0_ready, req1_ready, clr_busy,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start,
    output req0_ready, req1_ready, clr_busy,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the register file's single write port: round-robin arbitration of two
// writeback requesters plus a zero-fill clear sequencer, all outputs registered.
module rf_write_arbiter #(
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned DATA_W        = 8,
  parameter bit          ZERO_REG_LOCK = 1'b1,
  parameter bit          CLR_ON_RESET  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);
  localparam logic [0:0]        ST_ARB    = 1'b0;
  localparam logic [0:0]        ST_CLEAR  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              arb_open, grant0, grant1;

  // A clr_start in ARB blocks both grants that same cycle.
  always_comb begin
    arb_open = (state_q == ST_ARB) && !bus.clr_start;
    grant0   = arb_open && bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
    grant1   = arb_open && bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == ST_CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_q;
      wr_data_d = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) state_d = ST_ARB;
    end else if (bus.clr_start) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else if (grant0) begin
      wr_en_d   = !(ZERO_REG_LOCK && (bus.req0_addr == '0));
      wr_addr_d = bus.req0_addr;
      wr_data_d = bus.req0_data;
      rr_ptr_d  = 1'b1;
    end else if (grant1) begin
      wr_en_d   = !(ZERO_REG_LOCK && (bus.req1_addr == '0));
      wr_addr_d = bus.req1_addr;
      wr_data_d = bus.req1_data;
      rr_ptr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLR_ON_RESET ? ST_CLEAR : ST_ARB;
      rr_ptr_q  <= 1'b0;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.clr_busy   = (state_q == ST_CLEAR);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written clear/reset
// sequences and random traffic checked against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rf_write_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ZERO_REG_LOCK(1'b1), .CLR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model: pending clear writes as an address queue, plus the
  // identity of the last granted requester.
  int unsigned    mq[$];
  int             last_win;
  bit             mvalid = 1'b0;
  logic           m_en;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_clear();
    mq.delete();
    for (int unsigned i = 0; i < (1 << AW); i++) mq.push_back(i);
  endtask

  // One clock cycle: drive inputs, check readys mid-cycle, step the model,
  // then check the registered outputs 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic cs, output logic g0, output logic g1);
    bit busy, e0, e1;
    int unsigned a;
    rst = r;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.clr_start  = cs;
    #2;
    g0 = bus.req0_ready;
    g1 = bus.req1_ready;
    busy = (mq.size() != 0);
    e0 = !busy && !cs && v0 && (!v1 || last_win == 1);
    e1 = !busy && !cs && v1 && (!v0 || last_win == 0);
    if (mvalid && !r) begin
      chk("model_ready0", {31'd0, g0}, {31'd0, e0});
      chk("model_ready1", {31'd0, g1}, {31'd0, e1});
    end
    if (r) begin
      fill_clear();
      last_win = 1;
      m_en = 1'b0; m_addr = '0; m_data = '0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (busy) begin
        a = mq.pop_front();
        m_en = 1'b1; m_addr = a[AW-1:0]; m_data = '0;
      end else if (cs) begin
        fill_clear();
        m_en = 1'b0;
      end else if (e0) begin
        m_en = (a0 != 0); m_addr = a0; m_data = d0; last_win = 0;
      end else if (e1) begin
        m_en = (a1 != 0); m_addr = a1; m_data = d1; last_win = 1;
      end else begin
        m_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (mvalid) begin
      chk("model_wr_en",   {31'd0, bus.wr_en}, {31'd0, m_en});
      chk("model_wr_addr", {29'd0, bus.wr_addr}, {29'd0, m_addr});
      chk("model_wr_data", {24'd0, bus.wr_data}, {24'd0, m_data});
      chk("model_busy",    {31'd0, bus.clr_busy}, {31'd0, (mq.size() != 0)});
    end
  endtask

  typedef struct {
    logic r, v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic cs;
    logic er0, er1, een; logic [AW-1:0] eaddr; logic [DW-1:0] edata; logic ebusy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1, logic cs,
                              logic er0, logic er1, logic een, logic [AW-1:0] eaddr,
                              logic [DW-1:0] edata, logic ebusy);
    vec_t v;
    v.r = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.cs = cs;
    v.er0 = er0; v.er1 = er1; v.een = een; v.eaddr = eaddr; v.edata = edata; v.ebusy = ebusy;
    return v;
  endfunction

  initial begin
    logic g0, g1;
    logic p0, p1;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    logic [AW-1:0] seen;
    int unsigned guard;

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.clr_start  = 1'b0;
    @(posedge clk); #1;

    // Reset then automatic clear of addresses 0..7
    vt.push_back(mk(1,0,0,0,   0,0,0,0, 0,0, 0,0,8'h00,1));
    vt.push_back(mk(1,0,0,0,   0,0,0,0, 0,0, 0,0,8'h00,1));
    for (int unsigned i = 0; i < 8; i++)
      vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 1,AW'(i),8'h00,(i < 7)));
    // Single req0 write, then idle (wr_en drops, addr/data held)
    vt.push_back(mk(0,1,3,8'hA5, 0,0,0,0, 1,0, 1,3,8'hA5,0));
    vt.push_back(mk(0,0,0,0,     0,0,0,0, 0,0, 0,3,8'hA5,0));
    // req1 alone to bring the pointer back to req0
    vt.push_back(mk(0,0,0,0,     1,2,8'h11,0, 0,1, 1,2,8'h11,0));
    // Both valid for 4 cycles: req0, req1, req0, req1
    vt.push_back(mk(0,1,1,8'h10, 1,5,8'h50,0, 1,0, 1,1,8'h10,0));
    vt.push_back(mk(0,1,6,8'h60, 1,5,8'h50,0, 0,1, 1,5,8'h50,0));
    vt.push_back(mk(0,1,6,8'h60, 1,7,8'h70,0, 1,0, 1,6,8'h60,0));
    vt.push_back(mk(0,1,4,8'h40, 1,7,8'h70,0, 0,1, 1,7,8'h70,0));
    // req1 to register 0: accepted, no write strobe
    vt.push_back(mk(0,0,0,0,     1,0,8'hFF,0, 0,1, 0,0,8'hFF,0));
    vt.push_back(mk(0,0,0,0,     0,0,0,0,     0,0, 0,0,8'hFF,0));

    foreach (vt[i]) begin
      cyc(vt[i].r, vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1, vt[i].cs, g0, g1);
      if (!vt[i].r) begin
        chk($sformatf("vec%0d_ready0", i), {31'd0, g0}, {31'd0, vt[i].er0});
        chk($sformatf("vec%0d_ready1", i), {31'd0, g1}, {31'd0, vt[i].er1});
      end
      chk($sformatf("vec%0d_wr_en", i),   {31'd0, bus.wr_en},   {31'd0, vt[i].een});
      chk($sformatf("vec%0d_wr_addr", i), {29'd0, bus.wr_addr}, {29'd0, vt[i].eaddr});
      chk($sformatf("vec%0d_wr_data", i), {24'd0, bus.wr_data}, {24'd0, vt[i].edata});
      chk($sformatf("vec%0d_busy", i),    {31'd0, bus.clr_busy}, {31'd0, vt[i].ebusy});
    end

    // clr_start beats a pending req0; a second pulse mid-clear is ignored
    cyc(0, 1,2,8'h22, 0,0,0, 1, g0, g1);
    chk("clr_start_blocks_ready0", {31'd0, g0}, 32'd0);
    chk("clr_entry_no_write", {31'd0, bus.wr_en}, 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      cyc(0, 1,2,8'h22, 0,0,0, (i == 3), g0, g1);
      chk("clr_ready0_low", {31'd0, g0}, 32'd0);
      chk("clr_seq_addr", {29'd0, bus.wr_addr}, i);
      chk("clr_seq_en", {31'd0, bus.wr_en}, 32'd1);
    end
    chk("clr_done_busy", {31'd0, bus.clr_busy}, 32'd0);
    cyc(0, 1,2,8'h22, 0,0,0, 0, g0, g1);
    chk("post_clr_ready0", {31'd0, g0}, 32'd1);
    chk("post_clr_write", {bus.wr_en, 20'd0, bus.wr_addr, bus.wr_data}, {1'b1, 20'd0, 3'd2, 8'h22});

    // Reset in the middle of a clear, at address 4
    cyc(0, 0,0,0, 0,0,0, 1, g0, g1);
    seen = '0;
    guard = 0;
    while (seen != 3'd4 && guard < 20) begin
      cyc(0, 0,0,0, 0,0,0, 0, g0, g1);
      seen = bus.wr_addr;
      guard++;
    end
    chk("reach_clr_addr4", {29'd0, seen}, 32'd4);
    cyc(1, 0,0,0, 0,0,0, 0, g0, g1);
    chk("rst_mid_clr_outputs", {bus.wr_en, bus.clr_busy, 19'd0, bus.wr_addr, bus.wr_data},
        {1'b0, 1'b1, 19'd0, 3'd0, 8'h00});
    cyc(0, 0,0,0, 0,0,0, 0, g0, g1);
    chk("clr_restart_addr0", {bus.wr_en, 28'd0, bus.wr_addr}, {1'b1, 28'd0, 3'd0});
    for (int unsigned i = 0; i < 7; i++) cyc(0, 0,0,0, 0,0,0, 0, g0, g1);

    // Random traffic; requesters hold their request until accepted
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int unsigned n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pa0 = AW'($urandom); pd0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pa1 = AW'($urandom); pd1 = DW'($urandom);
      end
      cyc(($urandom_range(0, 149) == 0), p0, pa0, pd0, p1, pa1, pd1,
          ($urandom_range(0, 39) == 0), g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
